// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- 8N1 serial transmitter
//
// Sends one start bit (0), eight data bits LSB first and one stop bit (1).
// Each bit is held for BAUDRATE clock cycles.
//
// Ports
//   clk      in   system clock, all state changes on the rising edge
//   rst      in   asynchronous active-high reset
//   i_start  in   transmit request, accepted only while idle
//   i_data   in   byte to send, captured when the request is accepted
//   o_tx     out  serial line, idle high, driven straight from a flop
//   o_busy   out  high while a frame is in progress
//   o_done   out  one-cycle pulse in the first idle cycle after a frame
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int BAUDRATE = 1085
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    localparam int CW = (BAUDRATE > 1) ? $clog2(BAUDRATE) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUDRATE - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic          baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    // Next-state logic. o_tx is computed here from the *next* state so the
    // line changes on the same edge as the state register.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (i_start) begin
                    state_d = START;
                    shift_d = i_data;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                end
            end

            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end

            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    // bit_q wraps 7 -> 0 on the same edge that enters STOP.
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // Next bit is what will sit in bit 0 after the shift.
                        tx_d = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end

            STOP: begin
                tx_d = 1'b1;
                if (baud_end) begin
                    state_d = IDLE;
                    baud_d  = '0;
                    done_d  = 1'b1;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the shift register is a plain flop vector, not a memory,
            // so it is cleared by reset like the rest of the state.
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign o_tx   = tx_q;
    assign o_busy = (state_q != IDLE);
    assign o_done = done_q;

endmodule
